// File: rtl/pb_press_classifier.sv
`default_nettype none
// ============================================================================
// Module   : pb_press_classifier
// Brief    : Classifies debounced push-button presses into press / short /
//            long / auto-repeat / release pulses, plus held level and count.
// Revision : 1.0 - initial release
// ============================================================================
module pb_press_classifier #(
  parameter int LONG_CYCLES   = 8,
  parameter int REPEAT_CYCLES = 4,
  parameter int REPEAT_EN     = 1,
  parameter int CNT_W         = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pb_debounced,
  output logic       press_pulse,
  output logic       short_pulse,
  output logic       long_pulse,
  output logic       repeat_pulse,
  output logic       release_pulse,
  output logic       held,
  output logic [7:0] press_cnt
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_PRESSED = 2'd1;
  localparam logic [1:0] ST_HELD    = 2'd2;

  localparam logic [CNT_W-1:0] c_long_last = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_rpt_last  = CNT_W'(REPEAT_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_one       = CNT_W'(1);

  logic [1:0]       r_state;
  logic             r_pb_prev;
  logic [CNT_W-1:0] r_hold_cnt;
  logic [CNT_W-1:0] r_rpt_cnt;

  logic [1:0]       w_state_nxt;
  logic [CNT_W-1:0] w_hold_nxt;
  logic [CNT_W-1:0] w_rpt_nxt;
  logic [7:0]       w_cnt_nxt;
  logic             w_press;
  logic             w_short;
  logic             w_long;
  logic             w_repeat;
  logic             w_release;
  logic             w_press_edge;

  // pb_prev clears on reset, so a level already high at reset release is a press
  assign w_press_edge = pb_debounced & ~r_pb_prev;

  always_comb begin
    w_state_nxt = r_state;
    w_hold_nxt  = r_hold_cnt;
    w_rpt_nxt   = r_rpt_cnt;
    w_cnt_nxt   = press_cnt;
    w_press     = 1'b0;
    w_short     = 1'b0;
    w_long      = 1'b0;
    w_repeat    = 1'b0;
    w_release   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_press_edge) begin
          w_state_nxt = ST_PRESSED;
          w_hold_nxt  = c_one;
          w_press     = 1'b1;
          w_cnt_nxt   = press_cnt + 8'd1;
        end
      end
      ST_PRESSED: begin
        if (!pb_debounced) begin
          w_state_nxt = ST_IDLE;
          w_short     = 1'b1;
          w_release   = 1'b1;
        end else if (r_hold_cnt == c_long_last) begin
          w_state_nxt = ST_HELD;
          w_long      = 1'b1;
          w_rpt_nxt   = '0;
        end else begin
          w_hold_nxt = r_hold_cnt + c_one;
        end
      end
      ST_HELD: begin
        if (!pb_debounced) begin
          w_state_nxt = ST_IDLE;
          w_release   = 1'b1;
        end else if (REPEAT_EN != 0) begin
          if (r_rpt_cnt == c_rpt_last) begin
            w_repeat  = 1'b1;
            w_rpt_nxt = '0;
          end else begin
            w_rpt_nxt = r_rpt_cnt + c_one;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_pb_prev     <= 1'b0;
      r_hold_cnt    <= '0;
      r_rpt_cnt     <= '0;
      press_pulse   <= 1'b0;
      short_pulse   <= 1'b0;
      long_pulse    <= 1'b0;
      repeat_pulse  <= 1'b0;
      release_pulse <= 1'b0;
      held          <= 1'b0;
      press_cnt     <= 8'd0;
    end else begin
      r_state       <= w_state_nxt;
      r_pb_prev     <= pb_debounced;
      r_hold_cnt    <= w_hold_nxt;
      r_rpt_cnt     <= w_rpt_nxt;
      press_pulse   <= w_press;
      short_pulse   <= w_short;
      long_pulse    <= w_long;
      repeat_pulse  <= w_repeat;
      release_pulse <= w_release;
      held          <= (w_state_nxt != ST_IDLE);
      press_cnt     <= w_cnt_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pb_press_classifier.sv
`default_nettype none
// ============================================================================
// Module   : tb_pb_press_classifier
// Brief    : Scoreboard bench for pb_press_classifier (repeat on and off).
// Revision : 1.0 - initial release
// ============================================================================
module tb_pb_press_classifier;

  localparam int LONG_C = 8;
  localparam int RPT_C  = 4;

  logic clk = 1'b0;
  logic rst_n;
  logic pb_debounced;

  logic       a_press, a_short, a_long, a_rpt, a_rel, a_held;
  logic [7:0] a_cnt;
  logic       b_press, b_short, b_long, b_rpt, b_rel, b_held;
  logic [7:0] b_cnt;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [27:0] exp_q[$];

  // reference state: whether a press is in progress and how many high samples it has had
  bit m_in_press = 0;
  bit m_prev     = 0;
  int m_len      = 0;
  int m_cnt      = 0;

  always #5 clk = ~clk;

  pb_press_classifier #(.LONG_CYCLES(LONG_C), .REPEAT_CYCLES(RPT_C), .REPEAT_EN(1), .CNT_W(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .pb_debounced(pb_debounced),
    .press_pulse(a_press), .short_pulse(a_short), .long_pulse(a_long),
    .repeat_pulse(a_rpt), .release_pulse(a_rel), .held(a_held), .press_cnt(a_cnt)
  );

  pb_press_classifier #(.LONG_CYCLES(LONG_C), .REPEAT_CYCLES(RPT_C), .REPEAT_EN(0), .CNT_W(16)) u_dut_norpt (
    .clk(clk), .rst_n(rst_n), .pb_debounced(pb_debounced),
    .press_pulse(b_press), .short_pulse(b_short), .long_pulse(b_long),
    .repeat_pulse(b_rpt), .release_pulse(b_rel), .held(b_held), .press_cnt(b_cnt)
  );

  task automatic check(input string name, input logic [13:0] act, input logic [13:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d act=%h exp=%h (press,short,long,rpt,rel,held,cnt)", name, cyc, act, exp);
    end
  endtask

  task automatic model_step(input bit pb, input bit rst, output logic [13:0] ea, output logic [13:0] eb);
    bit pr, sh, lg, rp, rl;
    pr = 0; sh = 0; lg = 0; rp = 0; rl = 0;
    if (!rst) begin
      m_in_press = 0; m_prev = 0; m_len = 0; m_cnt = 0;
    end else begin
      if (!m_in_press) begin
        if (pb && !m_prev) begin
          m_in_press = 1; m_len = 1; pr = 1; m_cnt = (m_cnt + 1) % 256;
        end
      end else if (!pb) begin
        rl = 1; sh = (m_len < LONG_C); m_in_press = 0;
      end else begin
        m_len++;
        lg = (m_len == LONG_C);
        rp = (m_len > LONG_C) && (((m_len - LONG_C) % RPT_C) == 0);
      end
      m_prev = pb;
    end
    ea = {pr, sh, lg, rp,   rl, m_in_press, 8'(m_cnt)};
    eb = {pr, sh, lg, 1'b0, rl, m_in_press, 8'(m_cnt)};
  endtask

  task automatic drive(input bit pb, input bit rst);
    logic [13:0] ea, eb;
    @(negedge clk);
    if (!rst && rst_n) begin
      rst_n = 1'b0;
      pb_debounced = pb;
      #1;
      check("async_reset_a", {a_press, a_short, a_long, a_rpt, a_rel, a_held, a_cnt}, 14'h0);
      check("async_reset_b", {b_press, b_short, b_long, b_rpt, b_rel, b_held, b_cnt}, 14'h0);
    end
    rst_n = rst;
    pb_debounced = pb;
    model_step(pb, rst, ea, eb);
    exp_q.push_back({ea, eb});
  endtask

  task automatic pulse_train(input int hi, input int lo);
    repeat (hi) drive(1'b1, 1'b1);
    repeat (lo) drive(1'b0, 1'b1);
  endtask

  // monitor: compares every registered output against the queued expectation
  initial begin
    logic [27:0] e;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("dut_rpt",   {a_press, a_short, a_long, a_rpt, a_rel, a_held, a_cnt}, e[27:14]);
        check("dut_norpt", {b_press, b_short, b_long, b_rpt, b_rel, b_held, b_cnt}, e[13:0]);
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    pb_debounced = 1'b0;
    repeat (3) drive(1'b0, 1'b0);
    drive(1'b0, 1'b1);

    pulse_train(3, 3);
    pulse_train(7, 3);
    pulse_train(8, 3);
    pulse_train(20, 3);

    // reset while held with the button still down, then a fresh press on release
    repeat (12) drive(1'b1, 1'b1);
    repeat (3) drive(1'b1, 1'b0);
    pulse_train(5, 3);

    for (int i = 0; i < 256; i++) pulse_train(2, 2);

    // one-cycle low glitch in the middle of a long hold
    pulse_train(10, 1);
    pulse_train(10, 3);

    for (int i = 0; i < 300; i++) begin
      int hi, lo;
      hi = $urandom_range(1, 25);
      lo = $urandom_range(1, 4);
      pulse_train(hi, lo);
      if ($urandom_range(0, 19) == 0) begin
        bit lvl;
        lvl = 1'($urandom_range(0, 1));
        repeat (2) drive(lvl, 1'b0);
        drive(lvl, 1'b1);
      end
    end
    repeat (3) drive(1'b0, 1'b1);

    @(posedge clk);
    #3;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL queue_drain act=%0d exp=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
